// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the uart_rx_byte receiver.
//  - UART_DATA_BITS      : data bits per frame
//  - DEFAULT_CLKS_PER_BIT: 100 MHz / 115200 baud
//  - rx_state_t          : 3-bit receiver FSM encoding (RX_IDLE..RX_BREAK)
//  - parity_bad          : even-parity check over data + parity bit
package uart_rx_byte_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Even parity: data plus parity bit must hold an even number of ones.
    function automatic logic parity_bad(input logic [UART_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//  clk  in  system clock
//  rst  in  synchronous active-high reset; both flops load RESET_VAL
//  d    in  asynchronous input
//  q    out synchronised output (2-cycle latency)
module uart_rx_byte_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined). Oversamples rxd,
// rebuilds bytes LSB first and pushes each good byte into the RX FIFO with a
// one-cycle write strobe. Framing errors (bad stop bit, or parity mismatch in
// the parity build) and FIFO overruns are reported as one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
// Ports:
//  clk                   in   system clock
//  rst                   in   synchronous active-high reset
//  rxd                   in   asynchronous serial input, idle high
//  rx_fifo_data          out  last pushed byte
//  rx_fifo_write_enable  out  one-cycle push strobe
//  rx_fifo_full          in   FIFO full, push suppressed
//  frame_error           out  one-cycle pulse on bad stop (or parity) bit
//  overrun_error         out  one-cycle pulse when a good byte is dropped
//  rx_busy               out  high while the FSM is not idle
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_fifo_data,
    output logic       rx_fifo_write_enable,
    input  logic       rx_fifo_full,
    output logic       frame_error,
    output logic       overrun_error,
    output logic       rx_busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    rx_state_t  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        rxd_s;

    uart_rx_byte_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign rx_busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= RX_IDLE;
            cnt                  <= '0;
            bit_idx              <= '0;
            shreg                <= '0;
            rx_fifo_data         <= 8'h00;
            rx_fifo_write_enable <= 1'b0;
            frame_error          <= 1'b0;
            overrun_error        <= 1'b0;
        end else begin
            rx_fifo_write_enable <= 1'b0;
            frame_error          <= 1'b0;
            overrun_error        <= 1'b0;

            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) state <= RX_START;
                end

                // Re-check the line at mid start bit to reject short glitches.
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // Sample points are a whole bit apart from mid start bit,
                // so every data sample lands mid-bit.
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                // On mismatch the stop bit is skipped; a low line at this
                // point still has to be waited out before the next frame.
                RX_PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (parity_bad(shreg, rxd_s)) begin
                            frame_error <= 1'b1;
                            state       <= rxd_s ? RX_IDLE : RX_BREAK;
                        end else begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif

                // Leave at mid stop bit so a start bit that follows directly
                // after one stop bit is not missed. Full is evaluated here,
                // one cycle ahead of the strobe; only this block pushes, so
                // the FIFO cannot become full in between.
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= RX_IDLE;
                            if (rx_fifo_full) begin
                                overrun_error <= 1'b1;
                            end else begin
                                rx_fifo_write_enable <= 1'b1;
                                rx_fifo_data         <= shreg;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state       <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // Line held low: no new frames until it returns high.
                RX_BREAK: begin
                    cnt <= '0;
                    if (rxd_s) state <= RX_IDLE;
                end

                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       full;
    logic [7:0] data;
    logic       we;
    logic       fe;
    logic       ov;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Event log from the DUT, sampled on the falling edge.
    int         we_cnt = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         excl_viol = 0;
    logic [7:0] got_q[$];

    // Reference: last byte that the FIFO interface should present.
    logic [7:0] last_pushed;

    always #5 clk = ~clk;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rxd                  (rxd),
        .rx_fifo_data         (data),
        .rx_fifo_write_enable (we),
        .rx_fifo_full         (full),
        .frame_error          (fe),
        .overrun_error        (ov),
        .rx_busy              (busy)
    );

    always @(negedge clk) begin
        if (we) begin
            we_cnt++;
            got_q.push_back(data);
        end
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
        if ((int'(we) + int'(fe) + int'(ov)) > 1) excl_viol++;
    end

    task automatic send_bit(input logic b, input int n);
        rxd = b;
        repeat (n) @(negedge clk);
    endtask

    // Whole frame on the line; a bad stop bit keeps the line low for 40
    // cycles, then returns it high for two bit times.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, CPB);
`endif
        if (stop_ok) begin
            send_bit(1'b1, CPB);
        end else begin
            send_bit(1'b0, 40);
            send_bit(1'b1, 2 * CPB);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        rxd  = 1'b1;
        full = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (we !== 1'b0)    begin errors++; $display("FAIL reset_we got %b exp 0", we); end
        checks++; if (fe !== 1'b0)    begin errors++; $display("FAIL reset_fe got %b exp 0", fe); end
        checks++; if (ov !== 1'b0)    begin errors++; $display("FAIL reset_ov got %b exp 0", ov); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
        rst = 1'b0;
        last_pushed = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ff();
        int w0 = we_cnt, f0 = fe_cnt, o0 = ov_cnt;
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, 2 * CPB);
        last_pushed = 8'hFF;
        checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL ff_strobes got %0d exp 1", we_cnt - w0); end
        checks++; if (got_q.size() <= w0 || got_q[w0] !== 8'hFF) begin errors++; $display("FAIL ff_data got %h exp ff", data); end
        checks++; if (fe_cnt - f0 + ov_cnt - o0 !== 0) begin errors++; $display("FAIL ff_errors got %0d exp 0", fe_cnt - f0 + ov_cnt - o0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ff_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        int w0 = we_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        send_bit(1'b1, 2 * CPB);
        last_pushed = 8'hA3;
        checks++; if (we_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_strobes got %0d exp 2", we_cnt - w0); end
        checks++; if (got_q.size() <= w0 || got_q[w0] !== 8'h55) begin errors++; $display("FAIL b2b_first got %h exp 55", (got_q.size() > w0) ? got_q[w0] : 8'hxx); end
        checks++; if (got_q.size() <= w0 + 1 || got_q[w0+1] !== 8'hA3) begin errors++; $display("FAIL b2b_second got %h exp a3", (got_q.size() > w0 + 1) ? got_q[w0+1] : 8'hxx); end
    endtask

    task automatic test_glitch();
        int w0 = we_cnt, f0 = fe_cnt, o0 = ov_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
        send_bit(1'b1, 2 * CPB);
        checks++; if ((we_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0) !== 0) begin errors++; $display("FAIL glitch_events got %0d exp 0", (we_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0)); end
    endtask

    task automatic test_frame_error();
        int w0 = we_cnt, f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", fe_cnt - f0); end
        checks++; if (we_cnt - w0 !== 0) begin errors++; $display("FAIL ferr_strobes got %0d exp 0", we_cnt - w0); end
        w0 = we_cnt;
        send_frame(8'h12, 1'b1);
        send_bit(1'b1, 2 * CPB);
        last_pushed = 8'h12;
        checks++; if (got_q.size() <= w0 || got_q[w0] !== 8'h12 || we_cnt - w0 !== 1) begin errors++; $display("FAIL ferr_recover got %h/%0d exp 12/1", data, we_cnt - w0); end
    endtask

    task automatic test_overrun();
        int w0 = we_cnt, o0 = ov_cnt;
        full = 1'b1;
        send_frame(8'h81, 1'b1);
        send_bit(1'b1, 2 * CPB);
        full = 1'b0;
        checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ov_cnt - o0); end
        checks++; if (we_cnt - w0 !== 0) begin errors++; $display("FAIL ovr_strobes got %0d exp 0", we_cnt - w0); end
        checks++; if (data !== last_pushed) begin errors++; $display("FAIL ovr_data got %h exp %h", data, last_pushed); end
    endtask

    task automatic test_reset_midframe();
        int w0 = we_cnt;
        logic [7:0] d = 8'hF0;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(d[i], CPB);
        rxd = d[4];
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_pushed = 8'h00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", data); end
        send_bit(1'b1, 3 * CPB);
        checks++; if (we_cnt - w0 !== 0) begin errors++; $display("FAIL rstmid_strobes got %0d exp 0", we_cnt - w0); end
        w0 = we_cnt;
        send_frame(8'h0F, 1'b1);
        send_bit(1'b1, 2 * CPB);
        last_pushed = 8'h0F;
        checks++; if (got_q.size() <= w0 || got_q[w0] !== 8'h0F || we_cnt - w0 !== 1) begin errors++; $display("FAIL rstmid_next got %h/%0d exp 0f/1", data, we_cnt - w0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int w0 = we_cnt, f0 = fe_cnt;
        logic [7:0] d = 8'h07;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
        send_bit(1'b0, CPB);
        send_bit(1'b1, 3 * CPB);
        checks++; if (fe_cnt - f0 !== 1 || we_cnt - w0 !== 0) begin errors++; $display("FAIL par_bad got fe %0d we %0d exp 1 0", fe_cnt - f0, we_cnt - w0); end
        w0 = we_cnt;
        send_frame(8'h07, 1'b1);
        send_bit(1'b1, 2 * CPB);
        last_pushed = 8'h07;
        checks++; if (got_q.size() <= w0 || got_q[w0] !== 8'h07 || we_cnt - w0 !== 1) begin errors++; $display("FAIL par_good got %h/%0d exp 07/1", data, we_cnt - w0); end
    endtask
`endif

    // Random bytes, FIFO-full state and stop-bit faults against the rule:
    // bad stop -> frame error only; good stop -> push, or overrun if full.
    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            int w0 = we_cnt, f0 = fe_cnt, o0 = ov_cnt;
            logic [7:0] d   = 8'($urandom);
            logic       fl  = ($urandom_range(0, 3) == 0);
            logic       bad = ($urandom_range(0, 5) == 0);
            int exp_we = 0, exp_fe = 0, exp_ov = 0;
            full = fl;
            send_frame(d, !bad);
            send_bit(1'b1, CPB * $urandom_range(0, 2));
            if (bad) exp_fe = 1;
            else if (fl) exp_ov = 1;
            else begin
                exp_we = 1;
                last_pushed = d;
            end
            checks++; if (we_cnt - w0 !== exp_we) begin errors++; $display("FAIL rnd%0d_we got %0d exp %0d", n, we_cnt - w0, exp_we); end
            checks++; if (fe_cnt - f0 !== exp_fe) begin errors++; $display("FAIL rnd%0d_fe got %0d exp %0d", n, fe_cnt - f0, exp_fe); end
            checks++; if (ov_cnt - o0 !== exp_ov) begin errors++; $display("FAIL rnd%0d_ov got %0d exp %0d", n, ov_cnt - o0, exp_ov); end
            checks++; if (data !== last_pushed) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", n, data, last_pushed); end
        end
        full = 1'b0;
        send_bit(1'b1, 2 * CPB);
    endtask

    task automatic test_exclusive();
        checks++; if (excl_viol !== 0) begin errors++; $display("FAIL exclusive got %0d exp 0", excl_viol); end
    endtask

    initial begin
        rst  = 1'b1;
        rxd  = 1'b1;
        full = 1'b0;
        last_pushed = 8'h00;
        @(negedge clk);
        test_reset();
        test_ff();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
